// File: rtl/csr_pkg.sv
// Shared ecodes, CSR field positions and sequencer state for the exception controller.
package csr_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam int unsigned CRMD_IE = 2;
    localparam int unsigned CRMD_DA = 3;
    localparam int unsigned CRMD_PG = 4;

    localparam int unsigned ESTAT_HWI_LO   = 2;
    localparam int unsigned ESTAT_HWI_HI   = 9;
    localparam int unsigned ESTAT_TI       = 11;
    localparam int unsigned ESTAT_ECODE_LO = 16;
    localparam int unsigned ESTAT_ECODE_HI = 21;
    localparam int unsigned ESTAT_ESUB_LO  = 22;
    localparam int unsigned ESTAT_ESUB_HI  = 30;
    localparam int unsigned INT_BITS       = 13;

    localparam int unsigned TCFG_EN       = 0;
    localparam int unsigned TCFG_PERIODIC = 1;
    localparam int unsigned TCFG_INIT_LO  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StEnter,
        StReturn
    } excp_state_e;

endpackage

// File: rtl/csr_timer.sv
// Stable timer: TVAL down-counter and the TI interrupt flag.
module csr_timer
    import csr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tcfg_wr,
    input  logic                  ticlr_wr,
    input  logic [DATA_WIDTH-1:0] tcfg,
    output logic [DATA_WIDTH-1:0] tval,
    output logic                  ti
);

    logic                  load;
    logic                  fired;
    logic                  hit;
    logic [DATA_WIDTH-1:0] init_val;

    assign init_val = {tcfg[DATA_WIDTH-1:TCFG_INIT_LO], 2'b00};
    // One-shot mode raises TI only once per load; periodic mode never sets fired.
    assign hit = tcfg[TCFG_EN] & ~load & (tval == '0) & ~fired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load  <= 1'b0;
            tval  <= '0;
            ti    <= 1'b0;
            fired <= 1'b0;
        end else begin
            // The written TCFG value is only visible the cycle after tcfg_wr.
            load <= tcfg_wr;
            if (load) begin
                tval  <= init_val;
                fired <= 1'b0;
            end else if (tcfg[TCFG_EN]) begin
                if (tval != '0) begin
                    tval <= tval - DATA_WIDTH'(1);
                end else if (tcfg[TCFG_PERIODIC]) begin
                    tval <= init_val;
                end
                if (hit && !tcfg[TCFG_PERIODIC]) begin
                    fired <= 1'b1;
                end
            end
            if (hit) begin
                ti <= 1'b1;
            end else if (ticlr_wr) begin
                ti <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/csr_excp_ctrl.sv
// Exception/interrupt entry and ERTN sequencer for the CSR file.
// Define CSR_TIMER_EN to build the stable timer; otherwise TVAL and TI read as zero.
module csr_excp_ctrl
    import csr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [5:0]  TLBR_ECODE = ECODE_TLBR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit_valid,
    input  logic [DATA_WIDTH-1:0] commit_pc,
    input  logic                  excp_valid,
    input  logic [5:0]            excp_ecode,
    input  logic [8:0]            excp_esubcode,
    input  logic                  excp_badv_valid,
    input  logic [DATA_WIDTH-1:0] excp_badv,
    input  logic                  ertn_valid,
    input  logic [7:0]            hw_int,
    input  logic [DATA_WIDTH-1:0] csr_crmd,
    input  logic [DATA_WIDTH-1:0] csr_prmd,
    input  logic [DATA_WIDTH-1:0] csr_ecfg,
    input  logic [DATA_WIDTH-1:0] csr_estat,
    input  logic [DATA_WIDTH-1:0] csr_era,
    input  logic [DATA_WIDTH-1:0] csr_eentry,
    input  logic [DATA_WIDTH-1:0] csr_tlbrentry,
    input  logic [DATA_WIDTH-1:0] csr_tcfg,
    input  logic                  tcfg_wr,
    input  logic                  ticlr_wr,
    output logic                  csr_we,
    output logic [DATA_WIDTH-1:0] crmd_next,
    output logic [DATA_WIDTH-1:0] prmd_next,
    output logic [DATA_WIDTH-1:0] estat_next,
    output logic [DATA_WIDTH-1:0] era_next,
    output logic                  badv_we,
    output logic [DATA_WIDTH-1:0] badv_next,
    output logic [DATA_WIDTH-1:0] tval_next,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  busy
);

    excp_state_e           state;
    logic [DATA_WIDTH-1:0] tval;
    logic                  ti;
    logic [DATA_WIDTH-1:0] est_live;
    logic                  int_take;
    logic                  do_entry;
    logic                  do_ertn;
    logic                  entry_tlbr;
    logic [5:0]            ecode;
    logic [8:0]            esubcode;
    logic                  unused_ecfg;

    assign unused_ecfg = ^csr_ecfg[DATA_WIDTH-1:INT_BITS];

`ifdef CSR_TIMER_EN
    csr_timer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tcfg_wr  (tcfg_wr),
        .ticlr_wr (ticlr_wr),
        .tcfg     (csr_tcfg),
        .tval     (tval),
        .ti       (ti)
    );
`else
    logic unused_timer;
    assign unused_timer = ^{tcfg_wr, ticlr_wr, csr_tcfg};
    assign tval = '0;
    assign ti   = 1'b0;
`endif

    assign tval_next = tval;
    assign csr_we    = do_entry | do_ertn;
    // A taken interrupt replaces the exception, so its bad address is not recorded.
    assign badv_we   = do_entry & excp_badv_valid & ~int_take;
    assign badv_next = excp_badv;

    always_comb begin
        est_live = csr_estat;
        est_live[ESTAT_HWI_HI:ESTAT_HWI_LO] = hw_int;
        est_live[ESTAT_TI] = ti;

        int_take   = csr_crmd[CRMD_IE] & (|(est_live[INT_BITS-1:0] & csr_ecfg[INT_BITS-1:0]));
        do_entry   = (state == StIdle) & commit_valid & (excp_valid | int_take);
        do_ertn    = (state == StIdle) & commit_valid & ertn_valid & ~do_entry;
        ecode      = int_take ? ECODE_INT : excp_ecode;
        esubcode   = int_take ? 9'd0 : excp_esubcode;
        entry_tlbr = (ecode == TLBR_ECODE);

        crmd_next  = csr_crmd;
        prmd_next  = csr_prmd;
        estat_next = est_live;
        era_next   = csr_era;

        if (do_entry) begin
            prmd_next[2:0] = csr_crmd[2:0];
            crmd_next[2:0] = 3'b000;
            if (entry_tlbr) begin
                crmd_next[CRMD_DA] = 1'b1;
                crmd_next[CRMD_PG] = 1'b0;
            end
            estat_next[ESTAT_ECODE_HI:ESTAT_ECODE_LO] = ecode;
            estat_next[ESTAT_ESUB_HI:ESTAT_ESUB_LO]   = esubcode;
            era_next = commit_pc;
        end else if (do_ertn) begin
            crmd_next[2:0] = csr_prmd[2:0];
            if (csr_estat[ESTAT_ECODE_HI:ESTAT_ECODE_LO] == TLBR_ECODE) begin
                crmd_next[CRMD_DA] = 1'b0;
                crmd_next[CRMD_PG] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            busy           <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (do_entry) begin
                        state          <= StEnter;
                        redirect_valid <= 1'b1;
                        busy           <= 1'b1;
                        redirect_pc    <= entry_tlbr ? csr_tlbrentry : csr_eentry;
                    end else if (do_ertn) begin
                        state          <= StReturn;
                        redirect_valid <= 1'b1;
                        busy           <= 1'b1;
                        redirect_pc    <= csr_era;
                    end
                end
                default: begin
                    state          <= StIdle;
                    redirect_valid <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

    illegal_commit_while_busy: assert property (
        @(posedge clk) disable iff (rst) busy |-> !commit_valid
    );

endmodule

// File: tb/tb_csr_excp_ctrl.sv
// Scoreboard bench for csr_excp_ctrl: directed commits, reset during entry, stable timer.
module tb_csr_excp_ctrl;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid, excp_valid, excp_badv_valid, ertn_valid, tcfg_wr, ticlr_wr;
    logic [31:0] commit_pc, excp_badv;
    logic [5:0]  excp_ecode;
    logic [8:0]  excp_esubcode;
    logic [7:0]  hw_int;
    logic [31:0] csr_crmd, csr_prmd, csr_ecfg, csr_estat, csr_era;
    logic [31:0] csr_eentry, csr_tlbrentry, csr_tcfg;
    logic        csr_we, badv_we, redirect_valid, busy;
    logic [31:0] crmd_next, prmd_next, estat_next, era_next, badv_next, tval_next, redirect_pc;

    typedef struct {
        logic [31:0] crmd;
        logic [31:0] prmd;
        logic [31:0] estat;
        logic [31:0] era;
        logic        bwe;
        logic [31:0] badv;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] redir_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    csr_excp_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .excp_valid      (excp_valid),
        .excp_ecode      (excp_ecode),
        .excp_esubcode   (excp_esubcode),
        .excp_badv_valid (excp_badv_valid),
        .excp_badv       (excp_badv),
        .ertn_valid      (ertn_valid),
        .hw_int          (hw_int),
        .csr_crmd        (csr_crmd),
        .csr_prmd        (csr_prmd),
        .csr_ecfg        (csr_ecfg),
        .csr_estat       (csr_estat),
        .csr_era         (csr_era),
        .csr_eentry      (csr_eentry),
        .csr_tlbrentry   (csr_tlbrentry),
        .csr_tcfg        (csr_tcfg),
        .tcfg_wr         (tcfg_wr),
        .ticlr_wr        (ticlr_wr),
        .csr_we          (csr_we),
        .crmd_next       (crmd_next),
        .prmd_next       (prmd_next),
        .estat_next      (estat_next),
        .era_next        (era_next),
        .badv_we         (badv_we),
        .badv_next       (badv_next),
        .tval_next       (tval_next),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops an expectation whenever the DUT presents a write or a redirect.
    always @(negedge clk) begin
        if (!rst) begin
            if (csr_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_csr_we", 32'(csr_we), 32'd0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("crmd_next", crmd_next, e.crmd);
                    chk("prmd_next", prmd_next, e.prmd);
                    chk("estat_next", estat_next, e.estat);
                    chk("era_next", era_next, e.era);
                    chk("badv_we", 32'(badv_we), 32'(e.bwe));
                    if (e.bwe) chk("badv_next", badv_next, e.badv);
                end
            end else begin
                chk("badv_we_idle", 32'(badv_we), 32'd0);
            end
            if (redirect_valid) begin
                if (redir_q.size() == 0) begin
                    chk("unexpected_redirect", 32'(redirect_valid), 32'd0);
                end else begin
                    chk("redirect_pc", redirect_pc, redir_q.pop_front());
                    chk("busy_with_redirect", 32'(busy), 32'd1);
                end
            end
        end
    end

    task automatic set_csrs(input logic [31:0] crmd, input logic [31:0] prmd,
                            input logic [31:0] estat, input logic [31:0] era,
                            input logic [31:0] ecfg, input logic [7:0] hwi);
        csr_crmd = crmd; csr_prmd = prmd; csr_estat = estat; csr_era = era;
        csr_ecfg = ecfg; hw_int = hwi;
    endtask

    task automatic expect_wr(input logic [31:0] crmd, input logic [31:0] prmd,
                             input logic [31:0] estat, input logic [31:0] era,
                             input logic bwe, input logic [31:0] badv, input logic [31:0] rpc);
        wr_t e;
        e.crmd = crmd; e.prmd = prmd; e.estat = estat; e.era = era; e.bwe = bwe; e.badv = badv;
        wr_q.push_back(e);
        redir_q.push_back(rpc);
    endtask

    // Leaves the bench just after the decision edge; the next call absorbs the busy cycle.
    task automatic do_commit(input logic [31:0] pc, input logic ex, input logic [5:0] ec,
                             input logic [8:0] esc, input logic bv, input logic [31:0] ba,
                             input logic er);
        @(posedge clk); #1;
        commit_valid = 1'b1; commit_pc = pc; excp_valid = ex; excp_ecode = ec;
        excp_esubcode = esc; excp_badv_valid = bv; excp_badv = ba; ertn_valid = er;
        @(posedge clk); #1;
        commit_valid = 1'b0; excp_valid = 1'b0; ertn_valid = 1'b0; excp_badv_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        commit_valid = 0; excp_valid = 0; excp_badv_valid = 0; ertn_valid = 0;
        tcfg_wr = 0; ticlr_wr = 0; commit_pc = '0; excp_badv = '0; excp_ecode = '0;
        excp_esubcode = '0; csr_tcfg = '0;
        set_csrs(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 8'h0);
        csr_eentry = 32'h1C00_8000; csr_tlbrentry = 32'h1C00_F000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_csr_we", 32'(csr_we), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_tval", tval_next, 32'd0);
        chk("rst_estat_next", estat_next, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Syscall entry
        set_csrs(32'h7, 32'h0, 32'h0, 32'h0, 32'h0, 8'h0);
        expect_wr(32'h0, 32'h7, 32'h000B_0000, 32'h1C00_0100, 1'b0, 32'h0, 32'h1C00_8000);
        do_commit(32'h1C00_0100, 1'b1, ECODE_SYS, 9'h0, 1'b0, 32'h0, 1'b0);

        // TLB refill entry
        set_csrs(32'h13, 32'h0, 32'h0, 32'h0, 32'h0, 8'h0);
        expect_wr(32'h08, 32'h3, 32'h003F_0000, 32'h1C00_0200, 1'b1, 32'hDEAD_0000, 32'h1C00_F000);
        do_commit(32'h1C00_0200, 1'b1, ECODE_TLBR, 9'h0, 1'b1, 32'hDEAD_0000, 1'b0);

        // ERTN after refill
        set_csrs(32'h08, 32'h3, 32'h003F_0000, 32'h1C00_0200, 32'h0, 8'h0);
        expect_wr(32'h13, 32'h3, 32'h003F_0000, 32'h1C00_0200, 1'b0, 32'h0, 32'h1C00_0200);
        do_commit(32'h1C00_0210, 1'b0, 6'h0, 9'h0, 1'b0, 32'h0, 1'b1);

        // Exception and ERTN together: exception wins
        set_csrs(32'h3, 32'h0, 32'h0, 32'h1C00_0999, 32'h0, 8'h0);
        expect_wr(32'h0, 32'h3, 32'h000B_0000, 32'h1C00_0400, 1'b0, 32'h0, 32'h1C00_8000);
        do_commit(32'h1C00_0400, 1'b1, ECODE_SYS, 9'h0, 1'b0, 32'h0, 1'b1);

        // Plain ERTN, no DA/PG change
        set_csrs(32'h0, 32'h7, 32'h000B_0000, 32'h1C00_0500, 32'h0, 8'h0);
        expect_wr(32'h7, 32'h7, 32'h000B_0000, 32'h1C00_0500, 1'b0, 32'h0, 32'h1C00_0500);
        do_commit(32'h1C00_0504, 1'b0, 6'h0, 9'h0, 1'b0, 32'h0, 1'b1);

        // Exception bits without commit_valid produce nothing
        @(posedge clk); #1 excp_valid = 1'b1; excp_ecode = ECODE_SYS;
        @(negedge clk) chk("no_commit_no_we", 32'(csr_we), 32'd0);
        @(posedge clk); #1 excp_valid = 1'b0;

        // Interrupt overrides ADEF
        set_csrs(32'h4, 32'h0, 32'h0, 32'h0, 32'h4, 8'h01);
        expect_wr(32'h0, 32'h4, 32'h0000_0004, 32'h1C00_0300, 1'b0, 32'h0, 32'h1C00_8000);
        do_commit(32'h1C00_0300, 1'b1, ECODE_ADEF, 9'h1, 1'b0, 32'h0, 1'b0);

        // Interrupt overrides ERTN
        set_csrs(32'h4, 32'h2, 32'h0, 32'h1C00_0888, 32'h4, 8'h01);
        expect_wr(32'h0, 32'h4, 32'h0000_0004, 32'h1C00_0600, 1'b0, 32'h0, 32'h1C00_8000);
        do_commit(32'h1C00_0600, 1'b0, 6'h0, 9'h0, 1'b0, 32'h0, 1'b1);

        // Reset while in ENTER: write happens, redirect is dropped
        set_csrs(32'h7, 32'h0, 32'h0, 32'h0, 32'h0, 8'h0);
        wr_q.push_back('{crmd: 32'h0, prmd: 32'h7, estat: 32'h000B_0000, era: 32'h1C00_0700,
                         bwe: 1'b0, badv: 32'h0});
        @(posedge clk); #1;
        commit_valid = 1'b1; commit_pc = 32'h1C00_0700; excp_valid = 1'b1; excp_ecode = ECODE_SYS;
        @(posedge clk); #1;
        rst = 1'b1; commit_valid = 1'b0; excp_valid = 1'b0;
        @(negedge clk);
        chk("rst_enter_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_enter_busy", 32'(busy), 32'd0);
        chk("rst_enter_redirect_pc", redirect_pc, 32'd0);
        chk("rst_enter_csr_we", 32'(csr_we), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk) chk("post_rst_busy", 32'(busy), 32'd0);

        // Back in IDLE: a fresh commit is accepted
        expect_wr(32'h0, 32'h7, 32'h000B_0000, 32'h1C00_0800, 1'b0, 32'h0, 32'h1C00_8000);
        do_commit(32'h1C00_0800, 1'b1, ECODE_SYS, 9'h0, 1'b0, 32'h0, 1'b0);
        @(posedge clk); @(posedge clk);

        set_csrs(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 8'h0);
        @(posedge clk); #1 tcfg_wr = 1'b1;
        @(posedge clk); #1 tcfg_wr = 1'b0; csr_tcfg = 32'h0000_0013;
`ifdef CSR_TIMER_EN
        @(posedge clk);
        @(negedge clk) chk("tval_load", tval_next, 32'd16);
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("tval_zero", tval_next, 32'd0);
        chk("ti_before_set", 32'(estat_next[ESTAT_TI]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("ti_set", 32'(estat_next[ESTAT_TI]), 32'd1);
        chk("tval_reload", tval_next, 32'd16);
        @(posedge clk); #1 ticlr_wr = 1'b1;
        @(posedge clk); #1 ticlr_wr = 1'b0;
        @(negedge clk);
        chk("ti_cleared", 32'(estat_next[ESTAT_TI]), 32'd0);
        chk("tval_running", tval_next, 32'd14);
        repeat (14) @(posedge clk);
        #1 ticlr_wr = 1'b1;
        @(negedge clk) chk("tval_zero_again", tval_next, 32'd0);
        @(posedge clk); #1 ticlr_wr = 1'b0;
        @(negedge clk);
        chk("ti_set_beats_clear", 32'(estat_next[ESTAT_TI]), 32'd1);
        chk("tval_reload_again", tval_next, 32'd16);
`else
        repeat (20) @(posedge clk);
        #1 ticlr_wr = 1'b1;
        @(negedge clk);
        chk("no_timer_tval", tval_next, 32'd0);
        chk("no_timer_ti", 32'(estat_next[ESTAT_TI]), 32'd0);
        @(posedge clk); #1 ticlr_wr = 1'b0;
`endif

        repeat (3) @(posedge clk);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        chk("redirect_queue_drained", 32'(redir_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
